// File: rtl/ex_branch_unit_pkg.sv
// ---------------------------------------------------------------------------
// ex_branch_unit_pkg
// Shared pipeline definitions for the execute-stage branch logic.
//   DEFAULT_XLEN  : default data/address width
//   FLAG_E/FLAG_GT: bit positions of E (equal) and GT (greater-than) in Flag
//   branchCtrl_t  : decoded branch-type control bundle
// ---------------------------------------------------------------------------
package ex_branch_unit_pkg;

   localparam int DEFAULT_XLEN = 32;

   localparam int FLAG_E  = 1;
   localparam int FLAG_GT = 0;

   typedef struct packed {
      logic isRet;
      logic isBeq;
      logic isBgt;
      logic isUBranch;
   } branchCtrl_t;

endpackage : ex_branch_unit_pkg

// File: rtl/ex_branch_cond.sv
// ---------------------------------------------------------------------------
// ex_branch_cond
// Pure combinational branch decision: taken flag and redirect PC.
// Ports:
//   ctrl   in  branchCtrl_t  decoded branch controls
//   flag   in  2             {E, GT} from the preceding compare
//   target in  XLEN          precomputed target for b/beq/bgt/call
//   ra     in  XLEN          return address for ret
//   taken  out 1             any satisfied branch condition
//   pc     out XLEN          ret ? ra : target (driven even when not taken)
// ---------------------------------------------------------------------------
module ex_branch_cond
   import ex_branch_unit_pkg::*;
#(
   parameter int XLEN = DEFAULT_XLEN
) (
   input  branchCtrl_t     ctrl,
   input  logic [1:0]      flag,
   input  logic [XLEN-1:0] target,
   input  logic [XLEN-1:0] ra,
   output logic            taken,
   output logic [XLEN-1:0] pc
);

   always_comb begin
      // NOTE: every output gets a default before any condition so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      taken = 1'b0;
      pc    = target;

      // ret wins PC selection no matter what else is asserted.
      if (ctrl.isRet) begin
         taken = 1'b1;
         pc    = ra;
      end
      if (ctrl.isUBranch)                  taken = 1'b1;
      if (ctrl.isBeq && flag[FLAG_E])      taken = 1'b1;
      if (ctrl.isBgt && flag[FLAG_GT])     taken = 1'b1;
   end

endmodule : ex_branch_cond

// File: rtl/ex_branch_unit.sv
// ---------------------------------------------------------------------------
// ex_branch_unit
// Execute-stage branch resolution. Drives the fetch redirect combinationally
// and registers the decision for the EX/MA latch.
// Optional feature macro: EX_BRANCH_STATS_EN (adds branchCount / retCount).
// Ports:
//   clk           in  1     pipeline clock
//   rst_n         in  1     synchronous active-low reset
//   branchTarget  in  XLEN  target for b/beq/bgt/call
//   op1           in  XLEN  return address for ret
//   op2           in  XLEN  unused, kept for stage-interface uniformity
//   isRet/isBeq/isBgt/isUBranch in 1  decoded branch type
//   Flag          in  2     [1]=E, [0]=GT
//   isBranchTaken out 1     combinational redirect request
//   branchPC      out XLEN  combinational redirect PC
//   branchTaken_q out 1     registered isBranchTaken
//   branchPC_q    out XLEN  registered branchPC
//   branchCount   out 32    (stats only) cycles with isBranchTaken=1
//   retCount      out 32    (stats only) cycles with isRet=1
// ---------------------------------------------------------------------------
module ex_branch_unit
   import ex_branch_unit_pkg::*;
#(
   parameter int XLEN = DEFAULT_XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] branchTarget,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic            isRet,
   input  logic            isBeq,
   input  logic            isBgt,
   input  logic            isUBranch,
   input  logic [1:0]      Flag,
   output logic            isBranchTaken,
   output logic [XLEN-1:0] branchPC,
   output logic            branchTaken_q,
   output logic [XLEN-1:0] branchPC_q
`ifdef EX_BRANCH_STATS_EN
   ,
   output logic [31:0]     branchCount,
   output logic [31:0]     retCount
`endif
);

   branchCtrl_t ctrl;
   logic        unusedOp2;

   assign ctrl = '{isRet: isRet, isBeq: isBeq, isBgt: isBgt, isUBranch: isUBranch};

   // op2 is part of the uniform stage interface but carries nothing here.
   assign unusedOp2 = ^op2;

   ex_branch_cond #(.XLEN(XLEN)) uCond (
      .ctrl   (ctrl),
      .flag   (Flag),
      .target (branchTarget),
      .ra     (op1),
      .taken  (isBranchTaken),
      .pc     (branchPC)
   );

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         branchTaken_q <= 1'b0;
         branchPC_q    <= '0;
      end else begin
         branchTaken_q <= isBranchTaken;
         branchPC_q    <= branchPC;
      end
   end

`ifdef EX_BRANCH_STATS_EN
   // Free-running event counters; natural 32-bit wrap is intended.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         branchCount <= '0;
         retCount    <= '0;
      end else begin
         if (isBranchTaken) branchCount <= branchCount + 32'd1;
         if (isRet)         retCount    <= retCount + 32'd1;
      end
   end
`endif

endmodule : ex_branch_unit

// File: tb/tb_ex_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_branch_unit
// Self-checking bench for ex_branch_unit: directed cases followed by random
// stimulus compared against a behavioural reference model.
// Build with EX_BRANCH_STATS_EN defined to also check the counters.
// ---------------------------------------------------------------------------
module tb_ex_branch_unit;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [XLEN-1:0] branchTarget;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            isRet;
   logic            isBeq;
   logic            isBgt;
   logic            isUBranch;
   logic [1:0]      Flag;
   logic            isBranchTaken;
   logic [XLEN-1:0] branchPC;
   logic            branchTaken_q;
   logic [XLEN-1:0] branchPC_q;
`ifdef EX_BRANCH_STATS_EN
   logic [31:0]     branchCount;
   logic [31:0]     retCount;
`endif

   int nChecks = 0;
   int nErrors = 0;

   // Reference model state
   logic            expTakenQ = 1'b0;
   logic [XLEN-1:0] expPcQ    = '0;
   logic [31:0]     expBranchCount = '0;
   logic [31:0]     expRetCount    = '0;

   ex_branch_unit #(.XLEN(XLEN)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .branchTarget  (branchTarget),
      .op1           (op1),
      .op2           (op2),
      .isRet         (isRet),
      .isBeq         (isBeq),
      .isBgt         (isBgt),
      .isUBranch     (isUBranch),
      .Flag          (Flag),
      .isBranchTaken (isBranchTaken),
      .branchPC      (branchPC),
      .branchTaken_q (branchTaken_q),
      .branchPC_q    (branchPC_q)
`ifdef EX_BRANCH_STATS_EN
      ,
      .branchCount   (branchCount),
      .retCount      (retCount)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Taken if at least one of the instruction's conditions holds.
   function automatic logic modelTaken(input logic r, input logic u, input logic beq,
                                       input logic bgt, input logic [1:0] f);
      int satisfied = 0;
      bit eqFlag = (f >= 2'd2);      // E is the upper flag bit
      bit gtFlag = (f % 2 == 1);     // GT is the lower flag bit
      if (r) satisfied++;
      if (u) satisfied++;
      if (beq && eqFlag) satisfied++;
      if (bgt && gtFlag) satisfied++;
      return satisfied > 0;
   endfunction

   // One cycle: drive, check combinational outputs, clock, check registers.
   task automatic step(input string tag, input logic rv, input logic r, input logic u,
                       input logic beq, input logic bgt, input logic [1:0] f,
                       input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] a);
      logic            eTaken;
      logic [XLEN-1:0] ePc;
      rst_n = rv; isRet = r; isUBranch = u; isBeq = beq; isBgt = bgt;
      Flag = f; branchTarget = tgt; op1 = a; op2 = $urandom;
      eTaken = modelTaken(r, u, beq, bgt, f);
      ePc    = r ? a : tgt;
      #1;
      check({tag, ".taken"}, 64'(isBranchTaken), 64'(eTaken));
      check({tag, ".pc"},    64'(branchPC),      64'(ePc));
      @(posedge clk);
      if (!rv) begin
         expTakenQ = 1'b0; expPcQ = '0; expBranchCount = '0; expRetCount = '0;
      end else begin
         expTakenQ = eTaken; expPcQ = ePc;
         expBranchCount = expBranchCount + 32'(eTaken);
         expRetCount    = expRetCount + 32'(r);
      end
      #1;
      check({tag, ".taken_q"}, 64'(branchTaken_q), 64'(expTakenQ));
      check({tag, ".pc_q"},    64'(branchPC_q),    64'(expPcQ));
`ifdef EX_BRANCH_STATS_EN
      check({tag, ".branchCount"}, 64'(branchCount), 64'(expBranchCount));
      check({tag, ".retCount"},    64'(retCount),    64'(expRetCount));
`endif
   endtask

   initial begin
      rst_n = 1'b0; isRet = 0; isBeq = 0; isBgt = 0; isUBranch = 0;
      Flag = 2'b00; branchTarget = '0; op1 = '0; op2 = '0;
      #1;

      // Reset held for two edges with a taken branch on the inputs.
      step("rst0", 0, 0, 1, 0, 0, 2'b00, 32'h0000_ABCD, 32'h0);
      step("rst1", 0, 0, 1, 0, 0, 2'b00, 32'h0000_ABCD, 32'h0);
      check("rst.taken_q_zero", 64'(branchTaken_q), 64'd0);
      check("rst.pc_q_zero",    64'(branchPC_q),    64'd0);

      // Directed cases.
      step("ret",        1, 1, 0, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_1000);
      check("ret.pc_q_direct", 64'(branchPC_q), 64'h1000);
      check("ret.taken_q_direct", 64'(branchTaken_q), 64'd1);
      step("ubranch",    1, 0, 1, 0, 0, 2'b00, 32'h0000_2000, 32'h0);
      step("beq.E",      1, 0, 0, 1, 0, 2'b10, 32'h0000_3000, 32'h0);
      step("beq.noflag", 1, 0, 0, 1, 0, 2'b00, 32'h0000_4000, 32'h0);
      check("beq.noflag.taken_direct", 64'(isBranchTaken), 64'd0);
      check("beq.noflag.pc_direct",    64'(branchPC),      64'h4000);
      step("bgt.GT",     1, 0, 0, 0, 1, 2'b01, 32'h0000_5000, 32'h0);
      step("bgt.noflag", 1, 0, 0, 0, 1, 2'b00, 32'h0000_6000, 32'h0);
      step("bgt.Eonly",  1, 0, 0, 0, 1, 2'b10, 32'h0000_6100, 32'h0);
      step("beq.GTonly", 1, 0, 0, 1, 0, 2'b01, 32'h0000_6200, 32'h0);
      step("beqbgt.11",  1, 0, 0, 1, 1, 2'b11, 32'h0000_7000, 32'h0);
      step("retprio",    1, 1, 0, 1, 1, 2'b11, 32'h0000_7000, 32'h0000_8000);
      check("retprio.pc_direct", 64'(branchPC), 64'h8000);
      step("none.11",    1, 0, 0, 0, 0, 2'b11, 32'h0000_9000, 32'h0000_9999);

      // Mid-operation reset discards the in-flight decision.
      step("midrst",     0, 0, 1, 0, 0, 2'b00, 32'h0000_A000, 32'h0);

      // Count case: three taken cycles (one ret) and one not taken.
      step("cnt0", 1, 0, 1, 0, 0, 2'b00, 32'h0000_B000, 32'h0);
      step("cnt1", 1, 1, 0, 0, 0, 2'b00, 32'h0000_B100, 32'h0000_C000);
      step("cnt2", 1, 0, 0, 1, 0, 2'b10, 32'h0000_B200, 32'h0);
      step("cnt3", 1, 0, 0, 0, 1, 2'b10, 32'h0000_B300, 32'h0);
`ifdef EX_BRANCH_STATS_EN
      check("count.branch_direct", 64'(branchCount), 64'd3);
      check("count.ret_direct",    64'(retCount),    64'd1);
`endif

      // Randomized stimulus with occasional reset.
      for (int i = 0; i < 300; i++) begin
         logic [3:0] c = 4'($urandom);
         step("rand", ($urandom_range(0, 15) != 0), c[3], c[2], c[1], c[0],
              2'($urandom), $urandom, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule : tb_ex_branch_unit
